pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Drives the PLL reset, waits for a stable lock and then supervises it.
// A lock that never arrives is retried a limited number of times before
// the sequencer parks in FAIL. A lock lost while running restarts the
// sequence and is counted. pll_locked is asynchronous to refclk, so every
// decision is taken on a two-flop synchronized copy of it.

module pll_lock_sequencer #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_lock_cnt
);

  // The shared counter must reach the largest of the three terminal counts.
  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       retry_q;
  logic [3:0]       nxt_retry;
  logic [3:0]       retry_inc;
  logic [7:0]       lost_q;
  logic             lost_inc;
  logic             restart;
  logic             timed_state;
  logic             sync_meta;
  logic             locked_s;

  assign retry_inc = retry_q + 4'd1;

  // Any state change, or a relock request that re-enters RESET_PLL,
  // restarts the shared counter so each phase is timed from zero.
  assign restart = (nxt_state != cur_state) || relock_req;

  // Only the phases that have a terminal count need the counter running.
  assign timed_state = (cur_state == RESET_PLL) ||
                       (cur_state == WAIT_LOCK) ||
                       (cur_state == STABLE);

  // Two-flop synchronizer bringing the asynchronous lock flag into refclk.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      locked_s  <= sync_meta;
    end
  end

  // State register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cur_state <= RESET_PLL;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state decision, retry bookkeeping and lock-loss detection.
  always_comb begin
    nxt_state = cur_state;
    nxt_retry = retry_q;
    lost_inc  = 1'b0;
    case (cur_state)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          nxt_state = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          nxt_state = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          nxt_retry = retry_inc;
          if (retry_inc == RETRY_LIMIT) begin
            nxt_state = FAIL;
          end else begin
            nxt_state = RESET_PLL;
          end
        end
      end
      STABLE: begin
        if (!locked_s) begin
          nxt_state = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          nxt_state = RUN;
          nxt_retry = 4'd0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          nxt_state = RESET_PLL;
          lost_inc  = 1'b1;
        end
      end
      FAIL: begin
        nxt_state = FAIL;
      end
      default: begin
        nxt_state = RESET_PLL;
      end
    endcase
    if (relock_req) begin
      nxt_state = RESET_PLL;
      nxt_retry = 4'd0;
    end
  end

  // Shared phase counter: cleared on every transition, idle outside timed phases.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart || !timed_state) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Failed-attempt counter for the current sequence.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      retry_q <= 4'd0;
    end else begin
      retry_q <= nxt_retry;
    end
  end

  // Saturating count of lock losses seen while running.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lost_q <= 8'd0;
    end else if (lost_inc && (lost_q != 8'hFF)) begin
      lost_q <= lost_q + 8'd1;
    end
  end

  assign pll_rst       = (cur_state == RESET_PLL);
  assign ready         = (cur_state == RUN);
  assign fail          = (cur_state == FAIL);
  assign state         = cur_state;
  assign retry_cnt     = retry_q;
  assign lost_lock_cnt = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// Directed bench for the PLL lock sequencer. The stimulus queues every
// expected output change together with how many cycles the previous output
// value should have lasted. A monitor watches the outputs on the falling
// edge and checks each change it sees against the head of the queue.

module tb_pll_lock_sequencer;

  localparam int RST_C  = 4;
  localparam int TO_C   = 32;
  localparam int ST_C   = 8;
  localparam int MAXR_C = 3;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       ready;
  logic       fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] lost_lock_cnt;

  typedef struct {
    logic [2:0] st;
    logic       prst;
    logic       rdy;
    logic       fl;
    logic [3:0] rc;
    logic [7:0] lc;
    int         dwell;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;
  int   n_tag;

  pll_lock_sequencer #(
    .RST_CYCLES          (RST_C),
    .LOCK_TIMEOUT_CYCLES (TO_C),
    .LOCK_STABLE_CYCLES  (ST_C),
    .MAX_RETRIES         (MAXR_C)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .ready         (ready),
    .fail          (fail),
    .state         (state),
    .retry_cnt     (retry_cnt),
    .lost_lock_cnt (lost_lock_cnt)
  );

  // 100 MHz simulation clock, first rising edge at 5.
  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // Queue one expected output change; dwell is how long the prior value lasted.
  task automatic pushExp(input int st, input int rc, input int lc, input int dwell);
    exp_t e;
    e.st    = 3'(st);
    e.prst  = (st == 0);
    e.rdy   = (st == 3);
    e.fl    = (st == 4);
    e.rc    = 4'(rc);
    e.lc    = 8'(lc);
    e.dwell = dwell;
    e.tag   = n_tag;
    n_tag++;
    exp_q.push_back(e);
  endtask

  // Drive all inputs, then hold them for n cycles, ending 1 time unit after a rising edge.
  task automatic applyStimulus(input logic r, input logic lk, input logic rq, input int n);
    rst        = r;
    pll_locked = lk;
    relock_req = rq;
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Immediate comparison of every output against constant expectations.
  task automatic checkOutput(input string name, input int st, input int prst, input int rdy,
                             input int fl, input int rc, input int lc);
    logic [17:0] want;
    want = {3'(st), 1'(prst), 1'(rdy), 1'(fl), 4'(rc), 8'(lc)};
    n_vec++;
    if ({state, pll_rst, ready, fail, retry_cnt, lost_lock_cnt} !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got state=%0d pll_rst=%0b ready=%0b fail=%0b retry=%0d lost=%0d, expected state=%0d pll_rst=%0d ready=%0d fail=%0d retry=%0d lost=%0d",
               name, state, pll_rst, ready, fail, retry_cnt, lost_lock_cnt,
               st, prst, rdy, fl, rc, lc);
    end
  endtask

  // Monitor: every output change outside reset is checked against the queue head.
  initial begin
    int          cyc;
    int          first_cyc;
    logic [17:0] prev_obs;
    logic [17:0] cur_obs;
    exp_t        e;
    cyc       = 0;
    first_cyc = 0;
    prev_obs  = '0;
    forever begin
      @(negedge refclk);
      cyc++;
      cur_obs = {state, pll_rst, ready, fail, retry_cnt, lost_lock_cnt};
      if (rst) begin
        prev_obs  = cur_obs;
        first_cyc = cyc + 1;
      end else if (cur_obs !== prev_obs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL unexpected_change: got state=%0d retry=%0d lost=%0d at cycle %0d, expected no change",
                   state, retry_cnt, lost_lock_cnt, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((cur_obs !== {e.st, e.prst, e.rdy, e.fl, e.rc, e.lc}) ||
              ((cyc - first_cyc) != e.dwell)) begin
            n_err++;
            $display("[TB] FAIL event%0d: got state=%0d pll_rst=%0b ready=%0b fail=%0b retry=%0d lost=%0d after %0d cycles, expected state=%0d pll_rst=%0b ready=%0b fail=%0b retry=%0d lost=%0d after %0d cycles",
                     e.tag, state, pll_rst, ready, fail, retry_cnt, lost_lock_cnt, cyc - first_cyc,
                     e.st, e.prst, e.rdy, e.fl, e.rc, e.lc, e.dwell);
          end
        end
        prev_obs  = cur_obs;
        first_cyc = cyc;
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    n_vec = 0;
    n_err = 0;
    n_tag = 0;

    // Reset values while rst is held.
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("reset_values", 0, 1, 0, 0, 0, 0);

    // Clean start, lock arrives late, then a 3-cycle glitch at stable count 5.
    pushExp(1, 0, 0, RST_C);
    pushExp(2, 0, 0, 5);
    pushExp(1, 0, 0, ST_C);
    pushExp(2, 0, 0, 3);
    pushExp(3, 0, 0, ST_C);
    applyStimulus(1'b0, 1'b0, 1'b0, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 11);
    checkOutput("first_run", 3, 0, 1, 0, 0, 0);

    // 300 single-cycle lock losses; the first coincides with relock_req.
    for (int k = 1; k <= 300; k++) begin
      int lk;
      lk = (k > 255) ? 255 : k;
      pushExp(0, 0, lk, 4);
      pushExp(1, 0, lk, RST_C);
      pushExp(2, 0, lk, 1);
      pushExp(3, 0, lk, ST_C);
      if (k == 1) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 13);
        checkOutput("loss_with_relock", 3, 0, 1, 0, 0, 1);
      end else begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 15);
      end
    end
    checkOutput("lost_saturated", 3, 0, 1, 0, 0, 255);

    // Lock gone for good: three attempts, then FAIL.
    pushExp(0, 0, 255, 4);
    pushExp(1, 0, 255, RST_C);
    pushExp(0, 1, 255, TO_C);
    pushExp(1, 1, 255, RST_C);
    pushExp(0, 2, 255, TO_C);
    pushExp(1, 2, 255, RST_C);
    pushExp(4, 3, 255, TO_C);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 120);
    checkOutput("fail_hold", 4, 0, 0, 1, 3, 255);

    // Recovery from FAIL by relock_req with the PLL locking again.
    pushExp(0, 0, 255, 10);
    pushExp(1, 0, 255, RST_C);
    pushExp(2, 0, 255, 1);
    pushExp(3, 0, 255, ST_C);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 13);
    checkOutput("recovered", 3, 0, 1, 0, 0, 255);

    // Asynchronous reset between clock edges while running.
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 0, 1, 0, 0, 0, 0);
    pushExp(1, 0, 0, RST_C);
    pushExp(2, 0, 0, 1);
    pushExp(3, 0, 0, ST_C);
    @(posedge refclk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 14);
    checkOutput("run_after_reset", 3, 0, 1, 0, 0, 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL missing_events: got %0d events still pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
